// File: rtl/dcmi_ram_arb_pkg.sv
// -----------------------------------------------------------------------------
// dcmi_ram_arb_pkg
//   Shared definitions for the DCMI frame-SRAM arbiter:
//   - DMA_ADDR_LEN : word address width of the frame SRAM.
//   - arb_state_e  : 2-bit arbiter state / grant encoding.
//   - arb_pick()   : one-cycle winner selection between DMA and MCU.
// -----------------------------------------------------------------------------
package dcmi_ram_arb_pkg;

  localparam int DMA_ADDR_LEN = 16;

  typedef enum logic [1:0] {
    ARB_IDLE       = 2'd0,
    ARB_GNT_DMA    = 2'd1,
    ARB_GNT_MCU_WR = 2'd2,
    ARB_GNT_MCU_RD = 2'd3
  } arb_state_e;

  // Picks the grant state for the next cycle from the eligible requesters.
  // mcu_prio only matters when both are eligible in the same cycle.
  function automatic arb_state_e arb_pick(input logic dma_elig,
                                          input logic mcu_elig,
                                          input logic mcu_we,
                                          input logic mcu_prio);
    arb_state_e mcu_gnt;
    arb_state_e pick;
    mcu_gnt = mcu_we ? ARB_GNT_MCU_WR : ARB_GNT_MCU_RD;
    pick    = ARB_IDLE;
    if (dma_elig && mcu_elig) begin
      pick = mcu_prio ? mcu_gnt : ARB_GNT_DMA;
    end else if (dma_elig) begin
      pick = ARB_GNT_DMA;
    end else if (mcu_elig) begin
      pick = mcu_gnt;
    end
    return pick;
  endfunction

endpackage

// File: rtl/dcmi_ram_arb_if.sv
// -----------------------------------------------------------------------------
// dcmi_ram_arb_if
//   Bundles the three buses around the frame-SRAM arbiter:
//   - DMA write port : dma_req / dma_ack / dma_addr / dma_wdata
//   - MCU port       : mcu_req / mcu_we / mcu_ack / mcu_addr / mcu_wdata /
//                      mcu_rvld / mcu_rdata
//   - SRAM port      : ram_cs / ram_we / ram_addr / ram_wdata / ram_rdata
//
//   Handshake: a requester raises req with stable addr/data and holds it
//   until it sees a one-cycle ack; addr/data may change in the cycle after
//   ack. The arbiter never samples a requester during its own ack cycle.
//   A granted MCU read returns data one cycle after its ack with mcu_rvld.
//
//   Modports:
//   - master : the arbiter (drives acks, read return and SRAM strobes).
//   - slave  : the environment (requesters plus SRAM macro).
// -----------------------------------------------------------------------------
interface dcmi_ram_arb_if
  import dcmi_ram_arb_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_LEN,
  parameter int DATA_W = 32
);

  logic              dma_req;
  logic              dma_ack;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;

  logic              mcu_req;
  logic              mcu_we;
  logic              mcu_ack;
  logic [ADDR_W-1:0] mcu_addr;
  logic [DATA_W-1:0] mcu_wdata;
  logic              mcu_rvld;
  logic [DATA_W-1:0] mcu_rdata;

  logic              ram_cs;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    input  dma_req, dma_addr, dma_wdata,
    input  mcu_req, mcu_we, mcu_addr, mcu_wdata,
    input  ram_rdata,
    output dma_ack,
    output mcu_ack, mcu_rvld, mcu_rdata,
    output ram_cs, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    output dma_req, dma_addr, dma_wdata,
    output mcu_req, mcu_we, mcu_addr, mcu_wdata,
    output ram_rdata,
    input  dma_ack,
    input  mcu_ack, mcu_rvld, mcu_rdata,
    input  ram_cs, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/dcmi_ram_arb.sv
// -----------------------------------------------------------------------------
// dcmi_ram_arb
//   Arbitrates a single-port synchronous frame SRAM between the DCMI DMA
//   write stream and the MCU/AHB access path. All SRAM strobes and acks are
//   registered; MCU read data is returned one cycle after the read grant.
//   A saturating counter records cycles in which the DMA was eligible but
//   lost arbitration (overflow diagnosis).
//
// Ports:
//   clk           in   system clock
//   rstn          in   asynchronous active-low reset
//   block_en      in   block enable; low clears everything at the next edge
//   clr_stat      in   pulse, clears dma_stall_cnt (wins over an increment)
//   bus           -    dcmi_ram_arb_if.master (DMA, MCU and SRAM buses)
//   busy          out  grant in progress or read return pending
//   dma_stall_cnt out  saturating DMA stall count
//   state_dbg     out  current arbiter state (arb_state_e encoding)
// -----------------------------------------------------------------------------
module dcmi_ram_arb
  import dcmi_ram_arb_pkg::*;
#(
  parameter int ADDR_W   = DMA_ADDR_LEN,
  parameter int DATA_W   = 32,
  parameter bit MCU_PRIO = 1'b0,
  parameter int STALL_W  = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               block_en,
  input  logic               clr_stat,
  dcmi_ram_arb_if.master     bus,
  output logic               busy,
  output logic [STALL_W-1:0] dma_stall_cnt,
  output logic [1:0]         state_dbg
);

  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

  arb_state_e        state_q, state_d;
  logic              dma_ack_q, dma_ack_d;
  logic              mcu_ack_q, mcu_ack_d;
  logic              ram_cs_q, ram_cs_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              rvld_q, rvld_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic dma_elig;
  logic mcu_elig;

  // ---------------------------------------------------------------------------
  // State register. block_en low is a synchronous clear: the access on the
  // SRAM at the edge where block_en is sampled low still completes, but
  // nothing (ack, rvld, strobes) follows it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ARB_IDLE;
      dma_ack_q   <= 1'b0;
      mcu_ack_q   <= 1'b0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rvld_q      <= 1'b0;
      rdata_q     <= '0;
      stall_q     <= '0;
    end else if (!block_en) begin
      state_q     <= ARB_IDLE;
      dma_ack_q   <= 1'b0;
      mcu_ack_q   <= 1'b0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rvld_q      <= 1'b0;
      rdata_q     <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      dma_ack_q   <= dma_ack_d;
      mcu_ack_q   <= mcu_ack_d;
      ram_cs_q    <= ram_cs_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rvld_q      <= rvld_d;
      rdata_q     <= rdata_d;
      stall_q     <= stall_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. A requester is masked in its own ack cycle because its
  // address/data are being advanced then; this masking is also what makes
  // continuous requests from both sides alternate DMA/MCU regardless of
  // MCU_PRIO, and keeps MCU reads at least two cycles apart.
  // ---------------------------------------------------------------------------
  always_comb begin
    dma_elig = bus.dma_req & ~dma_ack_q;
    mcu_elig = bus.mcu_req & ~mcu_ack_q;
    state_d  = arb_pick(dma_elig, mcu_elig, bus.mcu_we, MCU_PRIO);
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered outputs, derived from the
  // grant chosen this cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    dma_ack_d   = (state_d == ARB_GNT_DMA);
    mcu_ack_d   = (state_d == ARB_GNT_MCU_WR) || (state_d == ARB_GNT_MCU_RD);
    ram_cs_d    = (state_d != ARB_IDLE);
    ram_we_d    = (state_d == ARB_GNT_DMA) || (state_d == ARB_GNT_MCU_WR);
    // Address/data hold their last values while idle.
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    case (state_d)
      ARB_GNT_DMA: begin
        ram_addr_d  = bus.dma_addr;
        ram_wdata_d = bus.dma_wdata;
      end
      ARB_GNT_MCU_WR, ARB_GNT_MCU_RD: begin
        ram_addr_d  = bus.mcu_addr;
        ram_wdata_d = bus.mcu_wdata;
      end
      default: ;
    endcase

    // SRAM data appears the cycle after the read strobe.
    rvld_d  = (state_q == ARB_GNT_MCU_RD);
    rdata_d = rvld_q ? bus.ram_rdata : rdata_q;

    stall_d = stall_q;
    if (clr_stat) begin
      stall_d = '0;
    end else if (dma_elig && (state_d != ARB_GNT_DMA) && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  // Read data is forwarded straight from the SRAM in the valid cycle and
  // held from the capture register afterwards.
  assign bus.mcu_rdata = rvld_q ? bus.ram_rdata : rdata_q;
  assign bus.mcu_rvld  = rvld_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.mcu_ack   = mcu_ack_q;
  assign bus.ram_cs    = ram_cs_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;

  assign busy          = (state_q != ARB_IDLE) | rvld_q;
  assign dma_stall_cnt = stall_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_dcmi_ram_arb.sv
// -----------------------------------------------------------------------------
// tb_dcmi_ram_arb
//   Two arbiters (MCU_PRIO = 0 and MCU_PRIO = 1) share one set of requester
//   stimulus. Each has a small SRAM read model. The MCU_PRIO = 0 instance has
//   every SRAM access and read return checked against an expected queue.
// -----------------------------------------------------------------------------
module tb_dcmi_ram_arb;
  import dcmi_ram_arb_pkg::*;

  localparam int AW = DMA_ADDR_LEN;
  localparam int DW = 32;
  localparam int SW = 16;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rstn;
  logic block_en;
  logic clr_stat;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- stimulus
  logic          dma_req, mcu_req, mcu_we;
  logic [AW-1:0] dma_addr, mcu_addr;
  logic [DW-1:0] dma_wdata, mcu_wdata;

  dcmi_ram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  dcmi_ram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  assign bus0.dma_req   = dma_req;
  assign bus0.dma_addr  = dma_addr;
  assign bus0.dma_wdata = dma_wdata;
  assign bus0.mcu_req   = mcu_req;
  assign bus0.mcu_we    = mcu_we;
  assign bus0.mcu_addr  = mcu_addr;
  assign bus0.mcu_wdata = mcu_wdata;
  assign bus1.dma_req   = dma_req;
  assign bus1.dma_addr  = dma_addr;
  assign bus1.dma_wdata = dma_wdata;
  assign bus1.mcu_req   = mcu_req;
  assign bus1.mcu_we    = mcu_we;
  assign bus1.mcu_addr  = mcu_addr;
  assign bus1.mcu_wdata = mcu_wdata;

  logic          busy0, busy1;
  logic [SW-1:0] stall0, stall1;
  logic [1:0]    state0, state1;

  dcmi_ram_arb #(.ADDR_W(AW), .DATA_W(DW), .MCU_PRIO(1'b0), .STALL_W(SW)) dut0 (
    .clk(clk), .rstn(rstn), .block_en(block_en), .clr_stat(clr_stat),
    .bus(bus0.master), .busy(busy0), .dma_stall_cnt(stall0), .state_dbg(state0)
  );

  dcmi_ram_arb #(.ADDR_W(AW), .DATA_W(DW), .MCU_PRIO(1'b1), .STALL_W(SW)) dut1 (
    .clk(clk), .rstn(rstn), .block_en(block_en), .clr_stat(clr_stat),
    .bus(bus1.master), .busy(busy1), .dma_stall_cnt(stall1), .state_dbg(state1)
  );

  // SRAM read model: word 0x20 holds 0xDEADBEEF, others a tagged address.
  function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] a);
    return (a == AW'(16'h20)) ? 32'hDEAD_BEEF : {16'hA5A5, a};
  endfunction

  always @(posedge clk) begin
    if (bus0.ram_cs && !bus0.ram_we) bus0.ram_rdata <= sram_word(bus0.ram_addr);
    if (bus1.ram_cs && !bus1.ram_we) bus1.ram_rdata <= sram_word(bus1.ram_addr);
  end

  // ---------------------------------------------------------------- scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [AW+DW:0] exp_q[$];     // {we, addr, wdata} of each dut0 SRAM access
  logic [DW-1:0]  exp_rd_q[$];  // dut0 read return data

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_acc(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({we, a, d});
  endtask

  always @(negedge clk) begin
    if (bus0.ram_cs) begin
      if (exp_q.size() == 0) check("acc_unexp", 64'(bus0.ram_addr), 64'hFFFF_FFFF);
      else check("acc", 64'({bus0.ram_we, bus0.ram_addr, bus0.ram_wdata}), 64'(exp_q.pop_front()));
    end
    if (bus0.mcu_rvld) begin
      if (exp_rd_q.size() == 0) check("rvld_unexp", 64'(bus0.mcu_rdata), 64'hFFFF_FFFF);
      else check("rdata", 64'(bus0.mcu_rdata), 64'(exp_rd_q.pop_front()));
    end
    if (bus0.dma_ack || bus0.mcu_ack) check("ack_excl0", 64'(bus0.dma_ack & bus0.mcu_ack), 64'd0);
    if (bus1.dma_ack || bus1.mcu_ack) check("ack_excl1", 64'(bus1.dma_ack & bus1.mcu_ack), 64'd0);
  end

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero0(input string tag);
    check({tag, "_dack"},  64'(bus0.dma_ack),   64'd0);
    check({tag, "_mack"},  64'(bus0.mcu_ack),   64'd0);
    check({tag, "_cs"},    64'(bus0.ram_cs),    64'd0);
    check({tag, "_we"},    64'(bus0.ram_we),    64'd0);
    check({tag, "_addr"},  64'(bus0.ram_addr),  64'd0);
    check({tag, "_wdata"}, 64'(bus0.ram_wdata), 64'd0);
    check({tag, "_rvld"},  64'(bus0.mcu_rvld),  64'd0);
    check({tag, "_rdata"}, 64'(bus0.mcu_rdata), 64'd0);
    check({tag, "_busy"},  64'(busy0),          64'd0);
    check({tag, "_stall"}, 64'(stall0),         64'd0);
    check({tag, "_state"}, 64'(state0),         64'(ARB_IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- main
  initial begin
    rstn = 1'b0; block_en = 1'b1; clr_stat = 1'b0;
    dma_req = 1'b0; mcu_req = 1'b0; mcu_we = 1'b0;
    dma_addr = '0; mcu_addr = '0; dma_wdata = '0; mcu_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero0("rst");
    check("rst_stall1", 64'(stall1), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    // DMA only: held request, address advanced after every ack.
    dma_req = 1'b1; dma_addr = AW'(16'h10); dma_wdata = 32'hA000_0010;
    push_acc(1'b1, AW'(16'h10), 32'hA000_0010);
    check("dma_c0_ack", 64'(bus0.dma_ack), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("dma_ack", 64'(bus0.dma_ack), 64'd1);
      check("dma_we", 64'(bus0.ram_we), 64'd1);
      check("dma_addr", 64'(bus0.ram_addr), 64'(16'h10 + k));
      if (k < 2) begin
        dma_addr  = AW'(16'h11 + k);
        dma_wdata = 32'hA000_0011 + k;
        push_acc(1'b1, AW'(16'h11 + k), 32'hA000_0011 + k);
        step();
        check("dma_gap_ack", 64'(bus0.dma_ack), 64'd0);
      end else begin
        dma_req = 1'b0;
      end
    end
    check("dma_stall", 64'(stall0), 64'd0);
    step();
    check("dma_idle_cs", 64'(bus0.ram_cs), 64'd0);
    check("dma_idle_busy", 64'(busy0), 64'd0);

    // MCU read of 0x20.
    mcu_req = 1'b1; mcu_we = 1'b0; mcu_addr = AW'(16'h20); mcu_wdata = '0;
    push_acc(1'b0, AW'(16'h20), '0);
    exp_rd_q.push_back(32'hDEAD_BEEF);
    step();
    check("rd_ack", 64'(bus0.mcu_ack), 64'd1);
    check("rd_cs", 64'(bus0.ram_cs), 64'd1);
    check("rd_we", 64'(bus0.ram_we), 64'd0);
    check("rd_busy1", 64'(busy0), 64'd1);
    mcu_req = 1'b0;
    step();
    check("rd_rvld", 64'(bus0.mcu_rvld), 64'd1);
    check("rd_data", 64'(bus0.mcu_rdata), 64'hDEAD_BEEF);
    check("rd_busy2", 64'(busy0), 64'd1);
    check("rd_ack2", 64'(bus0.mcu_ack), 64'd0);
    step();
    check("rd_rvld_pulse", 64'(bus0.mcu_rvld), 64'd0);
    check("rd_hold", 64'(bus0.mcu_rdata), 64'hDEAD_BEEF);
    check("rd_busy3", 64'(busy0), 64'd0);

    // Tie: both requesters raised together and held for three decisions.
    dma_req = 1'b1; dma_addr = AW'(16'h40); dma_wdata = 32'hD000_0040;
    mcu_req = 1'b1; mcu_we = 1'b1; mcu_addr = AW'(16'h50); mcu_wdata = 32'hC000_0050;
    push_acc(1'b1, AW'(16'h40), 32'hD000_0040);
    push_acc(1'b1, AW'(16'h50), 32'hC000_0050);
    push_acc(1'b1, AW'(16'h40), 32'hD000_0040);
    step();
    check("tie0_c1_dack", 64'(bus0.dma_ack), 64'd1);
    check("tie0_c1_mack", 64'(bus0.mcu_ack), 64'd0);
    check("tie1_c1_mack", 64'(bus1.mcu_ack), 64'd1);
    check("tie1_c1_dack", 64'(bus1.dma_ack), 64'd0);
    check("tie1_c1_stall", 64'(stall1), 64'd1);
    check("tie0_c1_stall", 64'(stall0), 64'd0);
    step();
    check("tie0_c2_mack", 64'(bus0.mcu_ack), 64'd1);
    check("tie1_c2_dack", 64'(bus1.dma_ack), 64'd1);
    step();
    check("tie0_c3_dack", 64'(bus0.dma_ack), 64'd1);
    check("tie1_c3_mack", 64'(bus1.mcu_ack), 64'd1);
    dma_req = 1'b0; mcu_req = 1'b0;
    step();
    check("tie0_c4_cs", 64'(bus0.ram_cs), 64'd0);
    check("tie0_c4_stall", 64'(stall0), 64'd0);
    check("tie1_c4_stall", 64'(stall1), 64'd1);

    // Saturation and clear on the MCU-priority instance.
    force dut1.stall_q = 16'hFFFE;
    #1;
    release dut1.stall_q;
    check("sat_preload", 64'(stall1), 64'hFFFE);
    for (int r = 0; r < 4; r++) begin
      dma_req = 1'b1; dma_addr = AW'(16'h70 + r); dma_wdata = 32'hB000_0070 + r;
      mcu_req = 1'b1; mcu_we = 1'b1; mcu_addr = AW'(16'h78); mcu_wdata = 32'h0;
      clr_stat = (r == 3);
      push_acc(1'b1, AW'(16'h70 + r), 32'hB000_0070 + r);
      step();
      clr_stat = 1'b0; dma_req = 1'b0; mcu_req = 1'b0;
      check("sat_mack1", 64'(bus1.mcu_ack), 64'd1);
      check("sat_dack0", 64'(bus0.dma_ack), 64'd1);
      check(r == 3 ? "clr_stall" : "sat_stall", 64'(stall1), r == 3 ? 64'd0 : 64'hFFFF);
      step();
    end
    check("clr_stall_hold", 64'(stall1), 64'd0);

    // block_en dropped during the cycle that carries an MCU read grant.
    mcu_req = 1'b1; mcu_we = 1'b0; mcu_addr = AW'(16'h21); mcu_wdata = '0;
    push_acc(1'b0, AW'(16'h21), '0);
    step();
    check("ben_ack", 64'(bus0.mcu_ack), 64'd1);
    check("ben_cs", 64'(bus0.ram_cs), 64'd1);
    block_en = 1'b0; mcu_req = 1'b0;
    step();
    chk_zero0("ben");
    block_en = 1'b1;
    step();
    check("ben_after_rvld", 64'(bus0.mcu_rvld), 64'd0);

    // Async reset asserted in the middle of a DMA grant.
    dma_req = 1'b1; dma_addr = AW'(16'h60); dma_wdata = 32'hE000_0060;
    step();
    check("arst_pre_ack", 64'(bus0.dma_ack), 64'd1);
    check("arst_pre_addr", 64'(bus0.ram_addr), 64'h60);
    #1;
    rstn = 1'b0; dma_req = 1'b0;
    #1;
    chk_zero0("arst");
    check("arst_dut1_cs", 64'(bus1.ram_cs), 64'd0);
    step();
    rstn = 1'b1;
    dma_req = 1'b1; dma_addr = AW'(16'h61); dma_wdata = 32'hE000_0061;
    push_acc(1'b1, AW'(16'h61), 32'hE000_0061);
    step();
    check("arst_post_ack", 64'(bus0.dma_ack), 64'd1);
    check("arst_post_addr", 64'(bus0.ram_addr), 64'h61);
    dma_req = 1'b0;
    step();
    step();

    check("acc_q_empty", 64'(exp_q.size()), 64'd0);
    check("rd_q_empty", 64'(exp_rd_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
